mm_result_collector: RTL and testbench
======================================

# mm_result_collector

Downstream stage of the matrix-multiply block. Captures the signed 12-bit result stream (`res_valid`, row-end pulses, illegal-job pulse) into one of two ping-pong banks. Replays each completed result matrix over a valid/ready port. The multiplier cannot be stalled, so the collector absorbs a full job while the previous one drains.

## Interface
- `DATA_W`, 12: result element width (signed).
- `DEPTH`, 16: elements per bank.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `res_valid` input 1: one result element on `res_data` this cycle.
- `res_data` input DATA_W: signed result element.
- `res_row_last` input 1: qualifies `res_valid`; this element ends a result row.
- `res_illegal` input 1: qualifies `res_valid`; job had illegal dimensions, `res_data` ignored.
- `mm_busy` input 1: multiplier job active; a 1→0 transition closes the job.
- `out_valid` output 1: readout beat available.
- `out_ready` input 1: consumer accepts the beat.
- `out_data` output DATA_W: element, row-major.
- `out_row_end` output 1: beat is the last of its row.
- `out_last` output 1: beat is the last of the matrix.
- `out_err` output 1: matrix is illegal, ragged or truncated (constant across all beats of that matrix).
- `out_cols` output 5: column count of the matrix being drained.
- `overrun` output 1: sticky; data arrived with both banks occupied. Cleared only by reset.

## Operation
- Bank states: EMPTY → FILLING → FULL → DRAINING → EMPTY.
- Write side:
  - The first `res_valid` while no bank is FILLING claims the lower-indexed EMPTY bank, which becomes FILLING.
  - Each `res_valid` writes `mem[wr_cnt]` and increments `wr_cnt`.
  - The column count latches `wr_cnt+1` at the first `res_row_last`.
  - A later `res_row_last` at a position that is not a multiple of cols sets bank `err` (ragged).
- Overflow: writes beyond DEPTH are dropped and set `err`. `wr_cnt` saturates at DEPTH.
- Illegal job: `res_valid && res_illegal` stores nothing, sets `err` and marks the bank `illegal`.
- Job close: a registered falling edge of `mm_busy` moves FILLING → FULL.
  - A FILLING bank with zero writes and not illegal is discarded to EMPTY.
  - A falling edge with no FILLING bank is ignored.
- No EMPTY bank at claim time: the whole job's data is dropped and `overrun` is set.
- Read side:
  - When idle, the oldest FULL bank becomes DRAINING (fill order tracked by a one-bit age flag).
  - Beats are emitted in index order; `rd_cnt` advances on `out_valid && out_ready`.
- Beat flags:
  - `out_row_end` asserts when the column index equals cols−1, or on the final beat.
  - `out_last` asserts when `rd_cnt == stored_count−1`.
- Illegal bank: exactly one beat, with `out_data=0` and `out_err=out_row_end=out_last=1`.
- A bank returns to EMPTY on the handshake of its `out_last` beat.
- Filling one bank while draining the other is fully concurrent. Same-bank read/write is impossible by construction.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_row_end=0`, `out_last=0`, `out_err=0`, `out_cols=0`, `overrun=0`. Both banks EMPTY; all counters 0.
- Write latency: element sampled at edge t is readable from edge t+1.
- Close latency:
  - `mm_busy` is sampled low at edge k after being high at k−1; the bank is FULL after edge k.
  - With the read side idle, `out_valid` rises after edge k+1.
- `out_valid`, `out_data` and the beat flags are registered and held stable until the handshake.
- Back-to-back beats are allowed with `out_ready` held high: one beat per cycle.
- After the final handshake, the next FULL bank's first beat appears one cycle later (a one-cycle gap).
- Close of bank X and `out_last` handshake of bank Y on the same edge: both take effect, and X starts draining on the next edge.
- Reset mid-operation: all stored data is discarded, `out_valid` drops immediately (asynchronously), and `overrun` clears.

## Structure
- Shared package `mm_pkg`:
  - `DATA_W`, `DEPTH`, the count width `$clog2(DEPTH)+1`.
  - Bank-state enum (`BANK_EMPTY`, `BANK_FILLING`, `BANK_FULL`, `BANK_DRAINING`).
- Sub-module `mm_result_bank`, instantiated twice. It holds:
  - DEPTH×DATA_W storage;
  - `wr_cnt`, the cols latch, `err` and `illegal` flags;
  - the state register;
  - a combinational read port.
- The top level holds the claim/close logic, age flag, drain sequencer, output register and `overrun`.

## Test plan
- 2×2 result 1, 2 (row_last), 3, 4 (row_last), then `mm_busy` falls, `out_ready=1`:
  - out 1, 2 with `row_end` on 2, 3, 4 with `row_end`+`last` on 4;
  - `out_cols=2`, `out_err=0`;
  - first beat 2 cycles after the busy fall.
- Illegal job (single `res_valid`+`res_illegal`, busy falls) → one beat: `out_data=0`, `err=row_end=last=1`.
- Backpressure: 3×1 result −5, 7, 2047 with `out_ready` toggling every cycle → each value held until accepted, order preserved, no duplicates.
- Ping-pong: job A (4 elements) drains with `out_ready=0` while job B (2 elements) is collected → after A's `last`, B follows one cycle later; `overrun=0`.
- Overrun: A and B both FULL with `out_ready=0`, job C arrives → `overrun=1` and stays set; A then B drain intact; C never appears.
- Overflow/ragged:
  - 20-element job → 16 beats, all with `out_err=1`, `out_last` on the 16th.
  - Rows of 3 then 2 → `out_err=1`.
  - Asserting `rst_n=0` mid-drain → `out_valid=0` at once.

Source files
------------

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared sizing constants and bank-state encoding for the
//               matrix-multiply result collector.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

    localparam int DATA_W = 12;                  // signed result element width
    localparam int DEPTH  = 16;                  // elements per bank
    localparam int ADDR_W = $clog2(DEPTH);       // element address width
    localparam int CNT_W  = $clog2(DEPTH) + 1;   // count width, holds 0..DEPTH

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/mm_result_bank.sv
`default_nettype none
// ============================================================================
// Module      : mm_result_bank
// Description : One ping-pong result bank: element storage, write counter,
//               column latch, error/illegal flags, lifecycle state and a
//               combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_result_bank
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              claim,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_row_last,
    input  logic              wr_illegal,
    input  logic              close,
    input  logic              start,
    input  logic              rel,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output bank_state_t       state,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  cols,
    output logic              err,
    output logic              illegal
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    bank_state_t       r_state;
    bank_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_cols;
    logic [CNT_W-1:0]  r_col_idx;
    logic              r_err;
    logic              r_illegal;
    logic              w_sat;
    logic              w_discard;
    logic              w_clear;
    logic              w_store;
    logic              w_col_wrap;

    assign w_sat      = (r_wr_cnt == c_depth);
    // A job that closes with nothing stored and no illegal marker leaves no trace
    assign w_discard  = (r_wr_cnt == '0) && !r_illegal;
    assign w_clear    = ((r_state == BANK_FILLING) && close && w_discard) ||
                        ((r_state == BANK_DRAINING) && rel);
    assign w_store    = wr_en && !wr_illegal && !w_sat;
    // Column position wraps at the latched row length; before the latch it never wraps
    assign w_col_wrap = (r_cols != '0) && (r_col_idx == r_cols - c_one);

    // Bank lifecycle next-state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BANK_EMPTY:    if (claim) w_state_nxt = BANK_FILLING;
            BANK_FILLING:  if (close) w_state_nxt = w_discard ? BANK_EMPTY : BANK_FULL;
            BANK_FULL:     if (start) w_state_nxt = BANK_DRAINING;
            BANK_DRAINING: if (rel)   w_state_nxt = BANK_EMPTY;
            default:                  w_state_nxt = BANK_EMPTY;
        endcase
    end

    // Bank state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BANK_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Element storage; contents are only meaningful below r_wr_cnt
    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wr_cnt[ADDR_W-1:0]] <= wr_data;
    end

    // Write counter, column latch, ragged/overflow/illegal tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt  <= '0;
            r_cols    <= '0;
            r_col_idx <= '0;
            r_err     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_clear) begin
            r_wr_cnt  <= '0;
            r_cols    <= '0;
            r_col_idx <= '0;
            r_err     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (wr_en) begin
            if (wr_illegal) begin
                r_err     <= 1'b1;
                r_illegal <= 1'b1;
            end else if (w_sat) begin
                r_err <= 1'b1;
            end else begin
                r_wr_cnt <= r_wr_cnt + c_one;
                if (wr_row_last) begin
                    r_col_idx <= '0;
                    if (r_cols == '0)     r_cols <= r_wr_cnt + c_one;
                    else if (!w_col_wrap) r_err  <= 1'b1;
                end else if (w_col_wrap) begin
                    r_col_idx <= '0;
                end else begin
                    r_col_idx <= r_col_idx + c_one;
                end
            end
        end
    end

    assign rd_data = r_mem[rd_addr];
    assign state   = r_state;
    assign count   = r_wr_cnt;
    assign cols    = r_cols;
    assign err     = r_err;
    assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: rtl/mm_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : mm_result_collector
// Description : Captures the matrix-multiply result stream into two ping-pong
//               banks and replays each completed matrix over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_result_collector
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_row_last,
    input  logic              res_illegal,
    input  logic              mm_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_row_end,
    output logic              out_last,
    output logic              out_err,
    output logic [CNT_W-1:0]  out_cols,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    bank_state_t       w_state   [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic [CNT_W-1:0]  w_count   [2];
    logic [CNT_W-1:0]  w_cols    [2];
    logic [1:0]        w_err, w_illegal, w_claim, w_wr_en, w_close, w_start, w_rel;
    logic              w_any_filling, w_any_empty, w_claim_idx, w_claim_try, w_close_evt;
    logic              w_full0, w_full1, w_start_go, w_start_idx, w_sel, w_hs;
    logic [CNT_W-1:0]  w_next_cnt, w_next_col, w_cols_s, w_count_s;
    logic              w_ill_s, w_err_s, w_nx_last, w_nx_row_end;
    logic [DATA_W-1:0] w_nx_data;

    logic              r_busy_d, r_dropping, r_overrun, r_older;
    logic              r_rd_active, r_rd_bank;
    logic [CNT_W-1:0]  r_rd_cnt, r_rd_col;
    logic              r_out_valid, r_out_row_end, r_out_last, r_out_err;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_out_cols;

    // ---------------- write side ----------------
    assign w_any_filling = (w_state[0] == BANK_FILLING) || (w_state[1] == BANK_FILLING);
    assign w_any_empty   = (w_state[0] == BANK_EMPTY)   || (w_state[1] == BANK_EMPTY);
    assign w_claim_idx   = (w_state[0] == BANK_EMPTY) ? 1'b0 : 1'b1;
    assign w_claim_try   = res_valid && !w_any_filling && !r_dropping;
    assign w_close_evt   = r_busy_d && !mm_busy;

    // ---------------- read side ----------------
    assign w_full0     = (w_state[0] == BANK_FULL);
    assign w_full1     = (w_state[1] == BANK_FULL);
    assign w_start_go  = !r_rd_active && (w_full0 || w_full1);
    assign w_start_idx = (w_full0 && w_full1) ? r_older : w_full1;
    assign w_hs        = r_out_valid && out_ready;
    // The sequencer either continues its current bank or opens the chosen new one
    assign w_sel       = r_rd_active ? r_rd_bank : w_start_idx;
    assign w_cols_s    = w_cols[w_sel];
    assign w_count_s   = w_count[w_sel];
    assign w_ill_s     = w_illegal[w_sel];
    assign w_err_s     = w_err[w_sel];
    assign w_next_cnt  = r_rd_active ? (r_rd_cnt + c_one) : '0;
    assign w_next_col  = !r_rd_active ? '0 :
                         (r_rd_col == w_cols_s - c_one) ? '0 : (r_rd_col + c_one);
    // An illegal bank collapses to a single zero beat carrying every flag
    assign w_nx_last    = w_ill_s || (w_next_cnt == w_count_s - c_one);
    assign w_nx_row_end = w_nx_last || (w_next_col == w_cols_s - c_one);
    assign w_nx_data    = w_ill_s ? '0 : w_rd_data[w_sel];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_claim[b] = w_claim_try && w_any_empty && (w_claim_idx == 1'(b));
        assign w_wr_en[b] = res_valid && ((w_state[b] == BANK_FILLING) || w_claim[b]);
        assign w_close[b] = w_close_evt && (w_state[b] == BANK_FILLING);
        assign w_start[b] = w_start_go && (w_start_idx == 1'(b));
        assign w_rel[b]   = w_hs && r_out_last && (r_rd_bank == 1'(b));

        mm_result_bank u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .claim       (w_claim[b]),
            .wr_en       (w_wr_en[b]),
            .wr_data     (res_data),
            .wr_row_last (res_row_last),
            .wr_illegal  (res_illegal),
            .close       (w_close[b]),
            .start       (w_start[b]),
            .rel         (w_rel[b]),
            .rd_addr     (w_next_cnt[ADDR_W-1:0]),
            .rd_data     (w_rd_data[b]),
            .state       (w_state[b]),
            .count       (w_count[b]),
            .cols        (w_cols[b]),
            .err         (w_err[b]),
            .illegal     (w_illegal[b])
        );
    end

    // Job close detection, overrun drop window and fill-order age flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_d   <= 1'b0;
            r_dropping <= 1'b0;
            r_overrun  <= 1'b0;
            r_older    <= 1'b0;
        end else begin
            r_busy_d <= mm_busy;
            // A job that finds no free bank is dropped entirely, up to its close
            if (w_close_evt)                     r_dropping <= 1'b0;
            else if (w_claim_try && !w_any_empty) r_dropping <= 1'b1;
            if (w_claim_try && !w_any_empty)     r_overrun  <= 1'b1;
            // The closing bank is older only if the other one is not already waiting
            if (w_close[0])      r_older <= w_full1;
            else if (w_close[1]) r_older <= !w_full0;
        end
    end

    // Drain sequencer and registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_active   <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_rd_cnt      <= '0;
            r_rd_col      <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_row_end <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_err     <= 1'b0;
            r_out_cols    <= '0;
        end else if (w_start_go) begin
            r_rd_active   <= 1'b1;
            r_rd_bank     <= w_start_idx;
            r_rd_cnt      <= '0;
            r_rd_col      <= '0;
            r_out_valid   <= 1'b1;
            r_out_data    <= w_nx_data;
            r_out_row_end <= w_nx_row_end;
            r_out_last    <= w_nx_last;
            r_out_err     <= w_err_s;
            r_out_cols    <= w_cols_s;
        end else if (w_hs) begin
            if (r_out_last) begin
                r_rd_active <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                r_rd_cnt      <= w_next_cnt;
                r_rd_col      <= w_next_col;
                r_out_data    <= w_nx_data;
                r_out_row_end <= w_nx_row_end;
                r_out_last    <= w_nx_last;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_row_end = r_out_row_end;
    assign out_last    = r_out_last;
    assign out_err     = r_out_err;
    assign out_cols    = r_out_cols;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mm_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_result_collector
// Description : Self-checking bench for mm_result_collector with a beat
//               scoreboard filled from an independent job model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_result_collector;
    import mm_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              row_end;
        logic              last;
        logic              err;
        logic [CNT_W-1:0]  cols;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              res_valid = 1'b0;
    logic [DATA_W-1:0] res_data = '0;
    logic              res_row_last = 1'b0;
    logic              res_illegal = 1'b0;
    logic              mm_busy = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_row_end;
    logic              out_last;
    logic              out_err;
    logic [CNT_W-1:0]  out_cols;
    logic              overrun;

    beat_t             exp_q[$];
    beat_t             mon_e;
    int                checks = 0;
    int                failures = 0;
    int                g_vals[32];
    bit                g_rl[32];
    bit                gap_check = 1'b0;
    int                gap_phase = 0;
    bit                prev_pend = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always #5 clk = ~clk;

    mm_result_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_row_last (res_row_last),
        .res_illegal  (res_illegal),
        .mm_busy      (mm_busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row_end  (out_row_end),
        .out_last     (out_last),
        .out_err      (out_err),
        .out_cols     (out_cols),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats of one job, derived from element list and row markers
    task automatic model_job(input int n, input bit ill);
        int    stored;
        int    cols;
        bit    err;
        beat_t b;
        if (ill) begin
            b = '{data: '0, row_end: 1'b1, last: 1'b1, err: 1'b1, cols: '0};
            exp_q.push_back(b);
            return;
        end
        stored = (n > DEPTH) ? DEPTH : n;
        cols   = 0;
        err    = (n > DEPTH);
        for (int i = 0; i < stored; i++) begin
            if (g_rl[i]) begin
                if (cols == 0)               cols = i + 1;
                else if ((i + 1) % cols != 0) err = 1'b1;
            end
        end
        for (int i = 0; i < stored; i++) begin
            b.data    = DATA_W'(g_vals[i]);
            b.last    = (i == stored - 1);
            b.row_end = b.last || ((cols != 0) && ((i % cols) == cols - 1));
            b.err     = err;
            b.cols    = CNT_W'(cols);
            exp_q.push_back(b);
        end
    endtask

    // Drive one job; the final tick is the edge that samples mm_busy low
    task automatic run_job(input int n, input bit ill, input bit expect_out);
        if (expect_out) model_job(n, ill);
        mm_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            res_valid    = 1'b1;
            res_data     = DATA_W'(g_vals[i]);
            res_row_last = g_rl[i];
            res_illegal  = ill;
            tick();
        end
        res_valid    = 1'b0;
        res_row_last = 1'b0;
        res_illegal  = 1'b0;
        mm_busy      = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input int maxc, input bit toggle);
        bit done;
        done = 1'b0;
        for (int c = 0; c < maxc && !done; c++) begin
            if (toggle) out_ready = ~out_ready;
            tick();
            done = (exp_q.size() == 0) && !out_valid;
        end
        chk("drain_done", 32'(done), 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic set_job(input int n, input int base, input int row_len);
        for (int i = 0; i < n; i++) begin
            g_vals[i] = base + i;
            g_rl[i]   = (row_len != 0) && ((i % row_len) == row_len - 1);
        end
    endtask

    // Beat monitor: scoreboard pop, stall stability and inter-matrix gap
    always @(negedge clk) begin
        if (rst_n) begin
            if (gap_phase == 1) begin
                chk("gap_low", 32'(out_valid), 32'd0);
                gap_phase = 2;
            end else if (gap_phase == 2) begin
                chk("gap_next", 32'(out_valid), 32'd1);
                gap_phase = 0;
            end
            if (prev_pend) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            prev_pend = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("data",    32'(out_data),    32'(mon_e.data));
                    chk("row_end", 32'(out_row_end), 32'(mon_e.row_end));
                    chk("last",    32'(out_last),    32'(mon_e.last));
                    chk("err",     32'(out_err),     32'(mon_e.err));
                    chk("cols",    32'(out_cols),    32'(mon_e.cols));
                    if (mon_e.last && gap_check) begin
                        gap_phase = 1;
                        gap_check = 1'b0;
                    end
                end
            end
        end else begin
            prev_pend = 1'b0;
            gap_phase = 0;
        end
    end

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_valid",   32'(out_valid),   32'd0);
        chk("rst_data",    32'(out_data),    32'd0);
        chk("rst_row_end", 32'(out_row_end), 32'd0);
        chk("rst_last",    32'(out_last),    32'd0);
        chk("rst_err",     32'(out_err),     32'd0);
        chk("rst_cols",    32'(out_cols),    32'd0);
        chk("rst_overrun", 32'(overrun),     32'd0);
        rst_n = 1'b1;
        tick();

        // 2x2 matrix, first beat two edges after mm_busy falls
        out_ready = 1'b1;
        g_vals[0] = 1; g_vals[1] = 2; g_vals[2] = 3; g_vals[3] = 4;
        g_rl[0] = 1'b0; g_rl[1] = 1'b1; g_rl[2] = 1'b0; g_rl[3] = 1'b1;
        run_job(4, 1'b0, 1'b1);
        chk("lat_close_edge", 32'(out_valid), 32'd0);
        tick();
        chk("lat_first_beat", 32'(out_valid), 32'd1);
        wait_drain(20, 1'b0);

        // Illegal job: one zero beat with every flag set
        g_vals[0] = 99; g_rl[0] = 1'b0;
        run_job(1, 1'b1, 1'b1);
        wait_drain(20, 1'b0);

        // Backpressure, 3x1 with ready toggling
        out_ready = 1'b0;
        g_vals[0] = -5; g_vals[1] = 7; g_vals[2] = 2047;
        g_rl[0] = 1'b1; g_rl[1] = 1'b1; g_rl[2] = 1'b1;
        run_job(3, 1'b0, 1'b1);
        wait_drain(40, 1'b1);

        // Ping-pong: A stalls while B is collected, B follows after a gap
        out_ready = 1'b0;
        set_job(4, 10, 2);
        run_job(4, 1'b0, 1'b1);
        set_job(2, 20, 2);
        run_job(2, 1'b0, 1'b1);
        gap_check = 1'b1;
        out_ready = 1'b1;
        wait_drain(40, 1'b0);
        chk("pingpong_overrun", 32'(overrun), 32'd0);

        // Overrun: third job while both banks are occupied is dropped
        out_ready = 1'b0;
        set_job(3, 30, 3);
        run_job(3, 1'b0, 1'b1);
        set_job(2, 40, 2);
        run_job(2, 1'b0, 1'b1);
        set_job(2, 50, 2);
        run_job(2, 1'b0, 1'b0);
        chk("overrun_set", 32'(overrun), 32'd1);
        gap_check = 1'b1;
        out_ready = 1'b1;
        wait_drain(40, 1'b0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Overflow: 20 elements in rows of 4
        set_job(20, -900, 4);
        run_job(20, 1'b0, 1'b1);
        wait_drain(60, 1'b0);

        // Ragged: rows of 3 then 2
        set_job(5, 100, 0);
        g_rl[2] = 1'b1; g_rl[4] = 1'b1;
        run_job(5, 1'b0, 1'b1);
        wait_drain(30, 1'b0);

        // Reset while a beat is stalled
        out_ready = 1'b0;
        set_job(4, 60, 2);
        run_job(4, 1'b0, 1'b1);
        tick();
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_valid", 32'(out_valid), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Recovery after reset
        out_ready = 1'b1;
        set_job(2, 70, 1);
        run_job(2, 1'b0, 1'b1);
        wait_drain(30, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
